vpu_wb_buffer: RTL

//  Downstream neighbour of the VPU execution unit: accepts result vectors (one VLANE_CNT-lane beat per

---
 rtl/vpu_pkg.sv | 18 +
 rtl/vpu_wb_fifo.sv | 63 ++++++
 rtl/vpu_wb_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vpu_pkg.sv
// VPU shared constants and types.
// Used by the write-back buffer and its FIFO.
package vpu_pkg;

  localparam int VPU_OPERAND_WIDTH = 8;
  localparam int VPU_VLANE_CNT     = 16;
  localparam int VPU_DATA_W        = VPU_OPERAND_WIDTH * VPU_VLANE_CNT;
  localparam int VPU_ADDR_WIDTH    = 16;
  localparam int VPU_CNT_WIDTH     = 8;
  localparam int VPU_FIFO_DEPTH    = 4;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_DONE
  } wb_state_t;

endpackage

// File: rtl/vpu_wb_fifo.sv
// Result-beat FIFO for the VPU write-back buffer.
// Synchronous, flushed by rst_n; head is the oldest entry.
module vpu_wb_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; push and pop together keep count
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count state, flushed on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vpu_wb_buffer.sv
// VPU write-back buffer: queues exec-unit result beats
// and commits them to SRAM at consecutive addresses.
module vpu_wb_buffer
  import vpu_pkg::*;
#(
  parameter int OPERAND_WIDTH = VPU_OPERAND_WIDTH,
  parameter int VLANE_CNT     = VPU_VLANE_CNT,
  parameter int ADDR_WIDTH    = VPU_ADDR_WIDTH,
  parameter int CNT_WIDTH     = VPU_CNT_WIDTH,
  parameter int FIFO_DEPTH    = VPU_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_i,
  input  logic [ADDR_WIDTH-1:0]              dst_addr_i,
  input  logic [CNT_WIDTH-1:0]               len_i,
  input  logic                               wb_data_valid_i,
  input  logic [OPERAND_WIDTH*VLANE_CNT-1:0] wb_data_i,
  output logic                               wb_data_ready_o,
  output logic                               sram_wreq_o,
  output logic [ADDR_WIDTH-1:0]              sram_waddr_o,
  output logic [OPERAND_WIDTH*VLANE_CNT-1:0] sram_wdata_o,
  input  logic                               sram_wack_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o
);

  localparam int DATA_W = OPERAND_WIDTH * VLANE_CNT;

  wb_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  wr_q, wr_d;
  logic                  err_q, err_d;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              push, pop;

  vpu_wb_fifo #(
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (wb_data_i),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Handshake decode: ready ignores same-cycle pop
  always_comb begin
    wb_data_ready_o = (state_q == WB_RUN) && !fifo_full
                      && (acc_q < len_q);
    push            = wb_data_valid_i && wb_data_ready_o;
    sram_wreq_o     = (state_q == WB_RUN) && !fifo_empty;
    pop             = sram_wreq_o && sram_wack_i;
    sram_waddr_o    = base_q + ADDR_WIDTH'(wr_q);
    sram_wdata_o    = sram_wreq_o ? fifo_head : '0;
    busy_o          = (state_q != WB_IDLE);
    done_o          = (state_q == WB_DONE);
    err_o           = err_q;
  end

  // Next-state: FSM, beat counters and sticky drop flag
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      WB_IDLE: begin
        if (start_i) begin
          base_d  = dst_addr_i;
          len_d   = len_i;
          acc_d   = '0;
          wr_d    = '0;
          err_d   = 1'b0;
          state_d = (len_i == '0) ? WB_DONE : WB_RUN;
        end
      end
      WB_RUN: begin
        if (push) acc_d = acc_q + 1'b1;
        if (pop) begin
          wr_d = wr_q + 1'b1;
          if (wr_q + 1'b1 == len_q) state_d = WB_DONE;
        end
      end
      WB_DONE: state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
    if (wb_data_valid_i && !wb_data_ready_o) err_d = 1'b1;
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

endmodule
